// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module      : uart_tx_fifo
// Description : Transmit holding buffer in front of the UART TX shifter.
//               Accepts characters from the THR write path and presents them
//               to the shifter over valid/ready with first-word fall-through.
//               Provides 16550-style THRE/TEMT status and a sticky
//               THR-empty interrupt request. FIFO mode uses DEPTH entries,
//               non-FIFO mode behaves as a single holding register.
//               Optional macro UART_TX_FIFO_THRESH_EN adds a refill
//               threshold comparator (thresh_in / below_thresh_out).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              wr_en_in,
  input  logic [7:0]        wr_data_in,
  input  logic              fifo_en_in,
  input  logic              clr_in,
  output logic              tx_valid_out,
  output logic [7:0]        thr_out,
  input  logic              tx_ready_in,
  input  logic              tx_busy_in,
  output logic [ADDR_W:0]   level_out,
  output logic              thre_out,
  output logic              temt_out,
  output logic              wr_drop_out,
  output logic              irq_thre_out,
  input  logic              irq_clr_in
`ifdef UART_TX_FIFO_THRESH_EN
  ,
  input  logic [ADDR_W:0]   thresh_in,
  output logic              below_thresh_out
`endif
);

  localparam logic [ADDR_W:0]   C_DEPTH    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   C_ONE      = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   C_ZERO     = '0;
  localparam logic [ADDR_W-1:0] C_PTR_ONE  = (ADDR_W)'(1);

  // Storage and bookkeeping state
  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_empty;
  logic              r_fifo_en;
  logic              r_wr_drop;
  logic              r_irq;

  // Next-state / qualifier wires
  logic [ADDR_W:0]   w_cap;
  logic              w_full;
  logic              w_clear;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic              w_irq_set;
  logic [ADDR_W:0]   w_count_nxt;

  // Decode push/pop/clear qualifiers and the next occupancy
  always_comb begin
    w_clear     = clr_in | (fifo_en_in != r_fifo_en);
    w_cap       = fifo_en_in ? C_DEPTH : C_ONE;
    w_full      = (r_count == w_cap);
    // Pop is suppressed under clear as well: the entry is being discarded,
    // and the shifter never sees a handshake on stale data.
    w_pop       = ~r_empty & tx_ready_in & ~w_clear;
    // A write into a full buffer is still accepted when a slot frees up
    // in the same cycle; clear wins over both.
    w_push      = wr_en_in & (~w_full | w_pop) & ~w_clear;
    w_drop      = wr_en_in & w_full & ~w_pop & ~w_clear;

    w_count_nxt = r_count;
    if (w_clear) begin
      w_count_nxt = C_ZERO;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + C_ONE;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - C_ONE;
    end

    // Interrupt fires on a transition to empty: a lone pop of the last
    // entry, or a clear that discards queued data.
    if (w_clear) begin
      w_irq_set = (r_count != C_ZERO);
    end else begin
      w_irq_set = w_pop & ~w_push & (r_count == C_ONE);
    end
  end

  // Character storage; contents are deliberately left unreset
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data_in;
    end
  end

  // Pointers, occupancy, empty flag and FIFO-enable history
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_empty   <= 1'b1;
      r_fifo_en <= 1'b0;
    end else begin
      r_fifo_en <= fifo_en_in;
      r_count   <= w_count_nxt;
      r_empty   <= (w_count_nxt == C_ZERO);
      if (w_clear) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
        end
      end
    end
  end

  // Drop pulse and sticky THR-empty interrupt (set beats acknowledge)
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_wr_drop <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_wr_drop <= w_drop;
      if (w_irq_set) begin
        r_irq <= 1'b1;
      end else if (irq_clr_in || w_push) begin
        r_irq <= 1'b0;
      end
    end
  end

`ifdef UART_TX_FIFO_THRESH_EN
  logic r_below;

  // Refill request tracks the occupancy that level_out will show
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_below <= 1'b1;
    end else begin
      r_below <= (w_count_nxt < thresh_in);
    end
  end

  assign below_thresh_out = r_below;
`endif

  assign tx_valid_out = ~r_empty;
  assign thr_out      = r_mem[r_rd_ptr];
  assign level_out    = r_count;
  assign thre_out     = r_empty;
  assign temt_out     = r_empty & ~tx_busy_in;
  assign wr_drop_out  = r_wr_drop;
  assign irq_thre_out = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo. Directed scenarios
//               followed by randomized traffic, compared against a queue
//               based reference model. Define UART_TX_FIFO_THRESH_EN to
//               also exercise the threshold comparator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              wr_en_in;
  logic [7:0]        wr_data_in;
  logic              fifo_en_in;
  logic              clr_in;
  logic              tx_valid_out;
  logic [7:0]        thr_out;
  logic              tx_ready_in;
  logic              tx_busy_in;
  logic [ADDR_W:0]   level_out;
  logic              thre_out;
  logic              temt_out;
  logic              wr_drop_out;
  logic              irq_thre_out;
  logic              irq_clr_in;
`ifdef UART_TX_FIFO_THRESH_EN
  logic [ADDR_W:0]   thresh_in;
  logic              below_thresh_out;
`endif

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .wr_en_in     (wr_en_in),
    .wr_data_in   (wr_data_in),
    .fifo_en_in   (fifo_en_in),
    .clr_in       (clr_in),
    .tx_valid_out (tx_valid_out),
    .thr_out      (thr_out),
    .tx_ready_in  (tx_ready_in),
    .tx_busy_in   (tx_busy_in),
    .level_out    (level_out),
    .thre_out     (thre_out),
    .temt_out     (temt_out),
    .wr_drop_out  (wr_drop_out),
    .irq_thre_out (irq_thre_out),
    .irq_clr_in   (irq_clr_in)
`ifdef UART_TX_FIFO_THRESH_EN
    ,
    .thresh_in        (thresh_in),
    .below_thresh_out (below_thresh_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0] m_q[$];
  bit         m_fen;
  bit         m_irq;
  bit         m_drop;
  logic [7:0] last_pop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_fen  = 1'b0;
    m_irq  = 1'b0;
    m_drop = 1'b0;
  endtask

  task automatic check_outputs(input bit busy);
    check("valid", tx_valid_out, (m_q.size() != 0));
    check("level", level_out, m_q.size());
    check("thre", thre_out, (m_q.size() == 0));
    check("temt", temt_out, (m_q.size() == 0) && !busy);
    check("drop", wr_drop_out, m_drop);
    check("irq", irq_thre_out, m_irq);
    if (m_q.size() != 0) check("thr", thr_out, m_q[0]);
`ifdef UART_TX_FIFO_THRESH_EN
    check("below", below_thresh_out, (m_q.size() < 4));
`endif
  endtask

  // One clock of stimulus: drive inputs, advance the model, check after edge
  task automatic step(input bit wr, input logic [7:0] d, input bit rdy,
                      input bit clr, input bit ic, input bit fen, input bit busy);
    bit clear, full, pop, push, set;
    int cap;
    wr_en_in    = wr;
    wr_data_in  = d;
    tx_ready_in = rdy;
    clr_in      = clr;
    irq_clr_in  = ic;
    fifo_en_in  = fen;
    tx_busy_in  = busy;

    clear = clr || (fen != m_fen);
    cap   = fen ? DEPTH : 1;
    full  = (m_q.size() == cap);
    pop   = (m_q.size() != 0) && rdy && !clear;
    push  = wr && (!full || pop) && !clear;
    set   = 1'b0;
    if (clear) begin
      set = (m_q.size() != 0);
      m_q.delete();
    end else begin
      if (pop) last_pop = m_q.pop_front();
      if (push) m_q.push_back(d);
      set = pop && !push && (m_q.size() == 0);
    end
    m_drop = wr && full && !pop && !clear;
    if (set) m_irq = 1'b1;
    else if (ic || push) m_irq = 1'b0;
    m_fen = fen;

    @(posedge clk_in);
    #1;
    check_outputs(busy);
  endtask

  task automatic idle(input bit fen);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, fen, 1'b0);
  endtask

  initial begin
    rst_in      = 1'b1;
    wr_en_in    = 1'b0;
    wr_data_in  = 8'h00;
    fifo_en_in  = 1'b1;
    clr_in      = 1'b0;
    tx_ready_in = 1'b0;
    tx_busy_in  = 1'b0;
    irq_clr_in  = 1'b0;
`ifdef UART_TX_FIFO_THRESH_EN
    thresh_in   = 5'd4;
`endif
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    // Reset values
    check("rst_valid", tx_valid_out, 1'b0);
    check("rst_level", level_out, 0);
    check("rst_thre", thre_out, 1'b1);
    check("rst_temt", temt_out, 1'b1);
    check("rst_drop", wr_drop_out, 1'b0);
    check("rst_irq", irq_thre_out, 1'b0);
    rst_in = 1'b0;
    idle(1'b1);
    idle(1'b1);

    // Single write then pop
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("a5_valid", tx_valid_out, 1'b1);
    check("a5_thr", thr_out, 8'hA5);
    check("a5_level", level_out, 1);
    check("a5_thre", thre_out, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("a5_pop_thre", thre_out, 1'b1);
    check("a5_pop_irq", irq_thre_out, 1'b1);
    check("a5_popped", last_pop, 8'hA5);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("irq_ack", irq_thre_out, 1'b0);

    // Fill to DEPTH, overflow write, drain in order
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ovf_level", level_out, 16);
    check("ovf_drop", wr_drop_out, 1'b1);
    idle(1'b1);
    check("ovf_drop_once", wr_drop_out, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      check("seq_head", thr_out, i);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    check("seq_empty", level_out, 0);

    // Full with simultaneous write and pop
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("full_rw_level", level_out, 16);
    check("full_rw_nodrop", wr_drop_out, 1'b0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("full_rw_last", last_pop, 8'h55);

    // Non-FIFO mode holding register
    idle(1'b0);
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("nf_drop", wr_drop_out, 1'b1);
    check("nf_level", level_out, 1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("nf_pop", last_pop, 8'h11);

    // Mode toggle with queued entries acts as a clear
    idle(1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("tog_pre_level", level_out, 5);
`ifdef UART_TX_FIFO_THRESH_EN
    check("th_at5", below_thresh_out, 1'b0);
`endif
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("tog_level", level_out, 0);
    check("tog_irq", irq_thre_out, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("tog_ack", irq_thre_out, 1'b0);

`ifdef UART_TX_FIFO_THRESH_EN
    idle(1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("th_at3", below_thresh_out, 1'b1);
    step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("th_at4", below_thresh_out, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("th_back3", below_thresh_out, 1'b1);
`endif

    // Randomized traffic against the model
    begin
      bit fen = 1'b1;
      for (int n = 0; n < 1500; n++) begin
        if ($urandom_range(0, 63) == 0) fen = ~fen;
        step($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 1) == 1,
             $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0, fen,
             $urandom_range(0, 1) == 1);
      end
    end

    // Asynchronous reset mid-stream
    idle(1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    rst_in = 1'b1;
    #1;
    model_reset();
    check("mid_rst_valid", tx_valid_out, 1'b0);
    check("mid_rst_level", level_out, 0);
    check("mid_rst_thre", thre_out, 1'b1);
    check("mid_rst_temt", temt_out, 1'b1);
    check("mid_rst_drop", wr_drop_out, 1'b0);
    check("mid_rst_irq", irq_thre_out, 1'b0);
`ifdef UART_TX_FIFO_THRESH_EN
    check("mid_rst_below", below_thresh_out, 1'b1);
`endif
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    idle(1'b1);
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("post_rst_thr", thr_out, 8'h5A);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
